// File: rtl/key_pkg.sv
// Shared key-event types, key codes and the round-robin pick used by the scheduler.
package key_pkg;

  localparam int NUM_KEYS = 4;
  localparam int KEY_W    = 2;

  typedef logic [KEY_W-1:0] key_code_t;

  localparam key_code_t KEY_A = 2'd0;
  localparam key_code_t KEY_B = 2'd1;
  localparam key_code_t KEY_C = 2'd2;
  localparam key_code_t KEY_D = 2'd3;

  // First requesting key found searching upward from last+1, wrapping; returns last when req==0.
  function automatic key_code_t rr_pick(input logic [NUM_KEYS-1:0] req, input key_code_t last);
    key_code_t idx;
    rr_pick = last;
    for (int k = NUM_KEYS; k >= 1; k--) begin
      idx = key_code_t'(int'(last) + k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchronizer, stability counter and debounced held bit with press pulse.
module key_debounce #(
  parameter int DB_CYCLES = 8,
  parameter int DB_W      = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic held,
  output logic press_pulse
);

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            held_q, held_d;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    held_d = held_q;
    cnt_d  = '0;
    if (~sync2_q != held_q) begin
      if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        held_d = ~held_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  assign held        = held_q;
  assign press_pulse = held_d & ~held_q;

endmodule

// File: rtl/key_event_scheduler.sv
// Debounced buttons -> pending presses -> round-robin grant -> event FIFO drained by valid/ready.
module key_event_scheduler
  import key_pkg::*;
#(
  parameter int DB_CYCLES  = 8,
  parameter int DB_W       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] btn_n,
  input  logic                clear,
  output logic                ev_valid,
  output logic [KEY_W-1:0]    ev_code,
  input  logic                ev_ready,
  output logic [NUM_KEYS-1:0] held,
  output logic                overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_KEYS-1:0] press;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_n       (btn_n[i]),
      .held        (held[i]),
      .press_pulse (press[i])
    );
  end

  logic [NUM_KEYS-1:0] pending_q, pending_d;
  key_code_t           last_q, last_d;
  logic                overflow_q, overflow_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  key_code_t           mem_q [FIFO_DEPTH];

  logic                grant_valid, push, pop;
  key_code_t           grant_idx;
  logic [NUM_KEYS-1:0] grant_vec;

  assign ev_valid = (count_q != '0);
  assign ev_code  = ev_valid ? mem_q[rd_ptr_q] : KEY_A;
  assign overflow = overflow_q;

  // Room is judged on the registered count, so a full queue grants nothing even while popping.
  always_comb begin
    grant_valid = (pending_q != '0) && (count_q < CNT_W'(FIFO_DEPTH));
    grant_idx   = rr_pick(pending_q, last_q);
    grant_vec   = '0;
    grant_vec[grant_idx] = grant_valid;
    push        = grant_valid && !clear;
    pop         = ev_valid && ev_ready && !clear;
  end

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    last_d     = last_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (clear) begin
      pending_d  = '0;
      overflow_d = 1'b0;
      last_d     = KEY_D;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      // A press on a key that is still pending merges into the queued request and is reported lost.
      pending_d = (pending_q & ~grant_vec) | (press & ~pending_q);
      if ((press & pending_q) != '0) overflow_d = 1'b1;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        last_d   = grant_idx;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      last_q     <= KEY_D;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: queue storage has no reset; entries are only read while count says they were written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= grant_idx;
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench: directed scenarios plus randomized press sets against an event-order model.
module tb_key_event_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn_n;
  logic       clear;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_ready;
  logic [3:0] held;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [1:0] got[$];
  logic [1:0] exp_q[$];
  int         last_m = 3;
  int         stab_viol = 0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [1:0] prev_code = 2'd0;

  key_event_scheduler #(.DB_CYCLES(8), .DB_W(4), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_n    (btn_n),
    .clear    (clear),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_ready (ev_ready),
    .held     (held),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Steps n cycles at negedges, driving ev_ready (0, 1 or random) and logging accepted events.
  task automatic run_cycles(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (prev_valid && !prev_ready && (!ev_valid || ev_code !== prev_code)) stab_viol++;
      case (mode)
        0:       ev_ready = 1'b0;
        1:       ev_ready = 1'b1;
        default: ev_ready = 1'($urandom_range(0, 1));
      endcase
      if (ev_valid && ev_ready) got.push_back(ev_code);
      prev_valid = ev_valid;
      prev_ready = ev_ready;
      prev_code  = ev_code;
    end
  endtask

  // Model: simultaneous presses are served in order starting just after the last granted key.
  task automatic expect_mask(input logic [3:0] mask);
    int nl;
    nl = last_m;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last_m + k) % 4;
      if (mask[i]) begin
        exp_q.push_back(2'(i));
        nl = i;
      end
    end
    last_m = nl;
  endtask

  function automatic bit q_same();
    if (got.size() != exp_q.size()) return 1'b0;
    foreach (got[i]) if (got[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    last_m = 3;
    exp_q.delete();
    got.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    btn_n = 4'hF;
    clear = 1'b0;
    ev_ready = 1'b0;
    #2;
    checks++;
    if ({ev_valid, ev_code, held, overflow} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got %b expected 00000000", {ev_valid, ev_code, held, overflow});
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_cycles(3, 1);
  endtask

  task automatic test_single_press();
    int vcount = 0;
    btn_n = 4'b1101;
    ev_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ev_valid) vcount++;
      if (k == 9) begin
        checks++;
        if (held[1] !== 1'b0) begin errors++; $display("FAIL single_held_early: got %b expected 0", held[1]); end
      end
      if (k == 10) begin
        checks++;
        if (held[1] !== 1'b1 || ev_valid !== 1'b0) begin
          errors++; $display("FAIL single_edge10: held=%b valid=%b expected held=1 valid=0", held[1], ev_valid);
        end
      end
      if (k == 11) begin
        checks++;
        if (ev_valid !== 1'b1 || ev_code !== 2'd1) begin
          errors++; $display("FAIL single_edge11: valid=%b code=%0d expected valid=1 code=1", ev_valid, ev_code);
        end
      end
    end
    checks++;
    if (vcount != 1) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 1", vcount); end
    last_m = 1;
    btn_n = 4'hF;
    got.delete();
    run_cycles(12, 1);
    checks++;
    if (held !== 4'h0 || got.size() != 0) begin
      errors++; $display("FAIL single_release: held=%b events=%0d expected held=0000 events=0", held, got.size());
    end
  endtask

  task automatic test_bounce();
    int seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (c % 3 == 0) btn_n[0] = ~btn_n[0];
      @(negedge clk);
      if (held[0] || ev_valid) seen++;
    end
    btn_n = 4'hF;
    got.delete();
    run_cycles(12, 1);
    checks++;
    if (seen != 0 || held !== 4'h0 || got.size() != 0) begin
      errors++; $display("FAIL bounce: seen=%0d held=%b events=%0d expected 0 0000 0", seen, held, got.size());
    end
  endtask

  task automatic test_all_four();
    pulse_clear();
    btn_n = 4'h0;
    run_cycles(16, 0);
    expect_mask(4'hF);
    checks++;
    if (ev_valid !== 1'b1 || held !== 4'hF || ev_code !== exp_q[0]) begin
      errors++; $display("FAIL all4_full: valid=%b held=%b code=%0d expected 1 1111 %0d", ev_valid, held, ev_code, exp_q[0]);
    end
    for (int j = 0; j < 4; j++) begin
      ev_ready = 1'b1;
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== exp_q[j]) begin
        errors++; $display("FAIL all4_pop%0d: valid=%b code=%0d expected 1 %0d", j, ev_valid, ev_code, exp_q[j]);
      end
      @(negedge clk);
    end
    checks++;
    if (ev_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL all4_drained: valid=%b overflow=%b expected 0 0", ev_valid, overflow);
    end
    exp_q.delete();
    btn_n = 4'hF;
    got.delete();
    run_cycles(12, 1);
  endtask

  task automatic test_rr_order();
    got.delete();
    btn_n = 4'b1011;
    run_cycles(14, 1);
    expect_mask(4'b0100);
    btn_n = 4'hF;
    run_cycles(12, 1);
    btn_n = 4'b0110;
    run_cycles(16, 1);
    expect_mask(4'b1001);
    btn_n = 4'hF;
    run_cycles(12, 1);
    checks++;
    if (!q_same()) begin errors++; $display("FAIL rr_order: got %p expected %p", got, exp_q); end
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow_clear();
    btn_n = 4'h0;
    run_cycles(16, 0);
    expect_mask(4'hF);
    btn_n = 4'hF;
    run_cycles(12, 0);
    btn_n = 4'b1110;
    run_cycles(12, 0);
    checks++;
    if (overflow !== 1'b0 || ev_code !== exp_q[0]) begin
      errors++; $display("FAIL ovf_first_press: overflow=%b code=%0d expected 0 %0d", overflow, ev_code, exp_q[0]);
    end
    btn_n = 4'hF;
    run_cycles(12, 0);
    btn_n = 4'b1110;
    run_cycles(12, 0);
    checks++;
    if (overflow !== 1'b1 || ev_valid !== 1'b1) begin
      errors++; $display("FAIL ovf_set: overflow=%b valid=%b expected 1 1", overflow, ev_valid);
    end
    pulse_clear();
    checks++;
    if (ev_valid !== 1'b0 || overflow !== 1'b0 || held !== 4'b0001) begin
      errors++; $display("FAIL clear: valid=%b overflow=%b held=%b expected 0 0 0001", ev_valid, overflow, held);
    end
    run_cycles(15, 1);
    checks++;
    if (got.size() != 0) begin errors++; $display("FAIL clear_no_event: got %0d events expected 0", got.size()); end
    btn_n = 4'hF;
    run_cycles(12, 1);
    got.delete();
  endtask

  task automatic test_async_reset();
    btn_n = 4'h0;
    run_cycles(16, 0);
    expect_mask(4'hF);
    run_cycles(1, 1);
    run_cycles(1, 0);
    checks++;
    if (ev_valid !== 1'b1 || ev_code !== exp_q[1]) begin
      errors++; $display("FAIL rst_pre_head: valid=%b code=%0d expected 1 %0d", ev_valid, ev_code, exp_q[1]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ev_valid, ev_code, held, overflow} !== 8'h00) begin
      errors++; $display("FAIL rst_async: got %b expected 00000000", {ev_valid, ev_code, held, overflow});
    end
    btn_n = 4'hF;
    @(negedge clk);
    reset_n = 1'b1;
    last_m = 3;
    exp_q.delete();
    got.delete();
    run_cycles(20, 1);
    checks++;
    if (got.size() != 0 || held !== 4'h0) begin
      errors++; $display("FAIL rst_stale: events=%0d held=%b expected 0 0000", got.size(), held);
    end
  endtask

  task automatic test_random();
    stab_viol = 0;
    prev_valid = 1'b0;
    for (int it = 0; it < 20; it++) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      btn_n = ~4'($urandom_range(0, 15));
      run_cycles($urandom_range(1, 5), 2);
      btn_n = 4'hF;
      run_cycles(4, 2);
      btn_n = ~mask;
      run_cycles($urandom_range(12, 20), 2);
      checks++;
      if (held !== mask) begin errors++; $display("FAIL rand%0d_held: got %b expected %b", it, held, mask); end
      btn_n = 4'hF;
      run_cycles(12, 2);
      run_cycles(8, 1);
      expect_mask(mask);
      checks++;
      if (!q_same()) begin errors++; $display("FAIL rand%0d_events: got %p expected %p", it, got, exp_q); end
      got.delete();
      exp_q.delete();
    end
    checks++;
    if (stab_viol != 0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rand_stability: violations=%0d overflow=%b expected 0 0", stab_viol, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_all_four();
    test_rr_order();
    test_overflow_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
